sd_spi_cmd: RTL and testbench

SD_SPI_CMD -- requirements
Module: sd_spi_cmd

---
 rtl/sd_spi_pkg.sv | 29 ++
 rtl/sd_crc7.sv | 29 ++
 rtl/sd_spi_cmd.sv | 200 ++++++++++++++++++++
 tb/tb_sd_spi_cmd.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD-card SPI command engine: FSM states,
// frame geometry and response-length limits.
package sd_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SEND,
        ST_WAIT_R,
        ST_RECV,
        ST_FIN
    } state_t;

    localparam int FRAME_BITS     = 48;
    localparam int PRE_CYCLES     = 8;
    localparam int MAX_RESP_BYTES = 5;

    // Response length request mapped onto the supported 1..5 byte range
    function automatic logic [2:0] clamp_resp_bytes(input logic [2:0] n);
        if (n == 3'd0) begin
            return 3'd1;
        end
        if (n > 3'(MAX_RESP_BYTES)) begin
            return 3'(MAX_RESP_BYTES);
        end
        return n;
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 generator (x^7 + x^3 + 1), one message bit per enable.
// Only present when SD_SPI_CMD_CRC7_EN is defined.
`ifdef SD_SPI_CMD_CRC7_EN
module sd_crc7 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic fb;

    assign fb = din ^ crc[6];

    // Shift the remainder left and fold the polynomial in on feedback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= 7'd0;
        end else if (clr) begin
            crc <= 7'd0;
        end else if (en) begin
            crc <= {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
        end
    end

endmodule
`endif

// File: rtl/sd_spi_cmd.sv
// SD-card SPI-mode command engine: 8 idle clocks, 48-bit command frame,
// wait for the response start bit, then capture a 1..5 byte response.
// SPI mode 0. Build macro SD_SPI_CMD_CRC7_EN makes the CRC7 internal.
module sd_spi_cmd
    import sd_spi_pkg::*;
#(
    parameter int RESP_TIMEOUT_BITS = 128,
    parameter int DIV_W             = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       cmd_index,
    input  logic [31:0]      cmd_arg,
    input  logic [6:0]       cmd_crc,
    input  logic [2:0]       resp_bytes,
    input  logic [DIV_W-1:0] div,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [39:0]      resp,
    output logic             sd_cclk,
    output logic             sd_cmd,
    input  logic             sd_data0
);

    localparam int WAIT_W = $clog2(RESP_TIMEOUT_BITS + 1);

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, hcnt_q;
    logic [47:0]        frame_q;
    logic [2:0]         nbytes_q;
    logic [5:0]         bit_cnt_q;
    logic [WAIT_W-1:0]  wait_cnt_q;
    logic [5:0]         rx_cnt_q;
    logic               sclk_q, mosi_q, timeout_q;
    logic [39:0]        resp_q;

    logic               launch, active, tick, rise, fall;
    logic               pre_last, send_last;
    logic [5:0]         tx_idx, rx_total;
    logic               tx_bit;

    assign launch    = (state_q == ST_IDLE) && start;
    assign active    = (state_q == ST_PRE) || (state_q == ST_SEND) ||
                       (state_q == ST_WAIT_R) || (state_q == ST_RECV);
    assign tick      = active && (hcnt_q == div_q - 1'b1);
    assign rise      = tick && !sclk_q;
    assign fall      = tick && sclk_q;
    assign pre_last  = (bit_cnt_q == 6'(PRE_CYCLES - 1));
    assign send_last = (bit_cnt_q == 6'(FRAME_BITS - 1));
    assign rx_total  = {nbytes_q, 3'b000};
    assign tx_idx    = (state_q == ST_PRE) ? 6'd0 : bit_cnt_q + 6'd1;

`ifdef SD_SPI_CMD_CRC7_EN
    logic [6:0] crc_val;
    logic [2:0] crc_sel;
    logic       crc_en;

    assign crc_sel = 3'(6'd46 - tx_idx);
    assign crc_en  = fall && (tx_idx < 6'd40) &&
                     ((state_q == ST_PRE && pre_last) || (state_q == ST_SEND && !send_last));

    sd_crc7 u_crc7 (
        .clk (clk),
        .rst (rst),
        .clr (launch),
        .en  (crc_en),
        .din (tx_bit),
        .crc (crc_val)
    );
`endif

    // Select the next frame bit to launch on the coming SCLK falling edge
    always_comb begin
        tx_bit = frame_q[6'd47 - tx_idx];
`ifdef SD_SPI_CMD_CRC7_EN
        if (tx_idx >= 6'd40 && tx_idx <= 6'd46) begin
            tx_bit = crc_val[crc_sel];
        end
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs; transitions out of the SCLK phases happen on falling edges
    always_comb begin
        state_d = state_q;
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_FIN);
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_PRE;
            ST_PRE:    if (fall && pre_last) state_d = ST_SEND;
            ST_SEND:   if (fall && send_last) state_d = ST_WAIT_R;
            ST_WAIT_R: begin
                if (fall) begin
                    if (rx_cnt_q != 6'd0) begin
                        state_d = ST_RECV;
                    end else if (wait_cnt_q == WAIT_W'(RESP_TIMEOUT_BITS)) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_RECV:   if (fall && rx_cnt_q == rx_total) state_d = ST_FIN;
            ST_FIN:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath: SCLK divider, frame shifting, response capture and timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            hcnt_q     <= '0;
            frame_q    <= '0;
            nbytes_q   <= '0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            rx_cnt_q   <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b1;
            timeout_q  <= 1'b0;
            resp_q     <= '1;
        end else if (launch) begin
            div_q      <= (div == '0) ? DIV_W'(1) : div;
            frame_q    <= {2'b01, cmd_index, cmd_arg, cmd_crc, 1'b1};
            nbytes_q   <= clamp_resp_bytes(resp_bytes);
            hcnt_q     <= '0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            rx_cnt_q   <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b1;
            timeout_q  <= 1'b0;
            resp_q     <= '1;
        end else if (active) begin
            if (tick) begin
                hcnt_q <= '0;
                sclk_q <= ~sclk_q;
            end else begin
                hcnt_q <= hcnt_q + 1'b1;
            end
            if (rise) begin
                if (state_q == ST_WAIT_R) begin
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                    if (!sd_data0) begin
                        rx_cnt_q   <= 6'd1;
                        resp_q[39] <= 1'b0;
                    end
                end else if (state_q == ST_RECV) begin
                    resp_q[6'd39 - rx_cnt_q] <= sd_data0;
                    rx_cnt_q                 <= rx_cnt_q + 6'd1;
                end
            end
            if (fall) begin
                case (state_q)
                    ST_PRE: begin
                        if (pre_last) begin
                            bit_cnt_q <= '0;
                            mosi_q    <= tx_bit;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                        end
                    end
                    ST_SEND: begin
                        if (send_last) begin
                            mosi_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                            mosi_q    <= tx_bit;
                        end
                    end
                    ST_WAIT_R: begin
                        if (rx_cnt_q == 6'd0 && wait_cnt_q == WAIT_W'(RESP_TIMEOUT_BITS)) begin
                            timeout_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end else begin
            hcnt_q <= '0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b1;
        end
    end

    assign sd_cclk = sclk_q;
    assign sd_cmd  = mosi_q;
    assign resp    = resp_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_sd_spi_cmd.sv
// Bench for sd_spi_cmd: a behavioural SD-card model replays a bit stream on
// MISO and records MOSI, while a reference model derives frame, response,
// timeout and timing from the command rules. Honours SD_SPI_CMD_CRC7_EN.
module tb_sd_spi_cmd;

    localparam int TIMEOUT_BITS = 128;
    localparam int STREAM_LEN   = 512;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        start      = 1'b0;
    logic [5:0]  cmd_index  = '0;
    logic [31:0] cmd_arg    = '0;
    logic [6:0]  cmd_crc    = '0;
    logic [2:0]  resp_bytes = '0;
    logic [7:0]  div        = '0;
    logic        busy, done, timeout;
    logic [39:0] resp;
    logic        sd_cclk, sd_cmd;
    logic        sd_data0   = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic stream [0:STREAM_LEN-1];
    int   div_exp = 1;

    int          rise_cnt  = 0;
    logic [55:0] mosi_cap  = '0;
    int          duty_err  = 0;
    int          done_cnt  = 0;
    int          done_cyc  = 0;
    int          cyc       = 0;
    int          run       = 0;
    logic        prev_lvl  = 1'b0;
    logic        prev_busy = 1'b0;

    logic [47:0] exp_frame;
    logic [39:0] exp_resp;
    logic        exp_timeout;
    int          exp_periods;
    int          exp_cycles;

    sd_spi_cmd dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cmd_index  (cmd_index),
        .cmd_arg    (cmd_arg),
        .cmd_crc    (cmd_crc),
        .resp_bytes (resp_bytes),
        .div        (div),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .resp       (resp),
        .sd_cclk    (sd_cclk),
        .sd_cmd     (sd_cmd),
        .sd_data0   (sd_data0)
    );

    always #5 clk = ~clk;

    // Card model and line monitor: records MOSI on SCLK rises, drives MISO on falls,
    // measures half-period lengths, SCLK periods and the cycle at which done appears
    always @(negedge clk) begin
        if (busy && !prev_busy) begin
            rise_cnt = 0;
            mosi_cap = '0;
            duty_err = 0;
            done_cnt = 0;
            done_cyc = 0;
            cyc      = 1;
            run      = 1;
            prev_lvl = sd_cclk;
            sd_data0 = 1'b1;
        end else if (busy) begin
            cyc++;
            if (sd_cclk == prev_lvl) begin
                run++;
            end else begin
                if (run != div_exp) duty_err++;
                if (sd_cclk) begin
                    if (rise_cnt < 56) mosi_cap = {mosi_cap[54:0], sd_cmd};
                    rise_cnt++;
                end else begin
                    if (rise_cnt >= 56 && rise_cnt - 56 < STREAM_LEN) sd_data0 = stream[rise_cnt - 56];
                    else sd_data0 = 1'b1;
                end
                run      = 1;
                prev_lvl = sd_cclk;
            end
        end else begin
            sd_data0 = 1'b1;
        end
        if (busy && done) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = cyc;
        end
        prev_busy = busy;
    end

    function automatic logic [6:0] crc7(input logic [39:0] bits);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = bits[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setStream(input int pad, input logic [39:0] data);
        for (int i = 0; i < STREAM_LEN; i++) stream[i] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (pad + k < STREAM_LEN) stream[pad + k] = data[39 - k];
        end
    endtask

    // Reference model: first 0 on MISO within the window starts the response
    task automatic computeExpected(input logic [5:0] idx, input logic [31:0] arg,
                                   input logic [6:0] crc, input logic [2:0] rb, input logic [7:0] dv);
        int         n, z;
        logic [6:0] crcx;
        n = (rb == 3'd0) ? 1 : (rb > 3'd5) ? 5 : int'(rb);
`ifdef SD_SPI_CMD_CRC7_EN
        crcx = crc7({2'b01, idx, arg});
`else
        crcx = crc;
`endif
        exp_frame = {2'b01, idx, arg, crcx, 1'b1};
        z = -1;
        for (int i = 0; i < TIMEOUT_BITS; i++) begin
            if (z < 0 && stream[i] == 1'b0) z = i;
        end
        exp_resp = '1;
        if (z < 0) begin
            exp_timeout = 1'b1;
            exp_periods = 8 + 48 + TIMEOUT_BITS;
        end else begin
            exp_timeout = 1'b0;
            for (int k = 0; k < 8 * n; k++) exp_resp[39 - k] = stream[z + k];
            exp_periods = 8 + 48 + z + 8 * n;
        end
        div_exp    = (dv == 8'd0) ? 1 : int'(dv);
        exp_cycles = 2 * div_exp * exp_periods + 1;
    endtask

    // Present a command and pulse start for one cycle (called on a falling clk edge)
    task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg,
                                 input logic [6:0] crc, input logic [2:0] rb, input logic [7:0] dv);
        computeExpected(idx, arg, crc, rb, dv);
        cmd_index  = idx;
        cmd_arg    = arg;
        cmd_crc    = crc;
        resp_bytes = rb;
        div        = dv;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        checkOutput("busy_after_start", 64'(busy), 64'd1);
    endtask

    // Wait for done (bounded), optionally disturbing inputs, then compare against the model
    task automatic finishTransaction(input bit disturb);
        int n;
        n = 0;
        while (!done && n < exp_cycles + 100) begin
            if (disturb && n == 4) begin
                start     = 1'b1;
                cmd_index = ~cmd_index;
                div       = div + 8'd3;
            end else if (disturb && n == 5) begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        #1;
        checkOutput("done_seen", 64'(done), 64'd1);
        checkOutput("timeout", 64'(timeout), 64'(exp_timeout));
        checkOutput("resp", 64'(resp), 64'(exp_resp));
        checkOutput("pre_clocks_mosi_high", 64'(mosi_cap[55:48]), 64'hFF);
        checkOutput("mosi_frame", 64'(mosi_cap[47:0]), 64'(exp_frame));
        checkOutput("sclk_periods", 64'(rise_cnt), 64'(exp_periods));
        checkOutput("cycles_to_done", 64'(done_cyc), 64'(exp_cycles));
        checkOutput("sclk_half_periods", 64'(duty_err), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("done_one_cycle", 64'(done), 64'd0);
        checkOutput("busy_released", 64'(busy), 64'd0);
        checkOutput("done_pulse_count", 64'(done_cnt), 64'd1);
        checkOutput("resp_hold", 64'(resp), 64'(exp_resp));
        if (disturb) begin
            repeat (10) @(negedge clk);
            checkOutput("second_start_ignored", 64'(busy), 64'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        int          n;
        logic [63:0] r;
        $display("[TB] sd_spi_cmd bench start");
        for (int i = 0; i < STREAM_LEN; i++) stream[i] = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_timeout", 64'(timeout), 64'd0);
        checkOutput("rst_resp", 64'(resp), 64'hFF_FFFF_FFFF);
        checkOutput("rst_sclk", 64'(sd_cclk), 64'd0);
        checkOutput("rst_mosi", 64'(sd_cmd), 64'd1);
        rst = 1'b0;

        $display("[TB] CMD0 at div 125, start on first edge after reset");
        setStream(16, 40'h01_FFFF_FFFF);
        applyStimulus(6'd0, 32'h0, 7'h4A, 3'd1, 8'd125);
        finishTransaction(1'b0);
        checkOutput("cmd0_r1", 64'(resp[39:32]), 64'h01);

        $display("[TB] CMD8 with R7 response");
        setStream(5, 40'h01_0000_01AA);
        applyStimulus(6'd8, 32'h0000_01AA, 7'h43, 3'd5, 8'd2);
        finishTransaction(1'b0);
        checkOutput("cmd8_r7", 64'(resp), 64'h01_0000_01AA);

        $display("[TB] MISO stuck high");
        setStream(STREAM_LEN, 40'hFF_FFFF_FFFF);
        applyStimulus(6'd55, 32'h1234_5678, 7'h2B, 3'd1, 8'd2);
        finishTransaction(1'b0);

        $display("[TB] start bit on last and first-too-late sample");
        setStream(TIMEOUT_BITS - 1, 40'h5A_C3FF_FFFF);
        applyStimulus(6'd17, 32'hCAFE_0001, 7'h11, 3'd2, 8'd1);
        finishTransaction(1'b0);
        setStream(TIMEOUT_BITS, 40'h00_0000_0000);
        applyStimulus(6'd17, 32'hCAFE_0002, 7'h12, 3'd2, 8'd1);
        finishTransaction(1'b0);

        $display("[TB] reset during frame bit 20");
        setStream(10, 40'h00_FFFF_FFFF);
        applyStimulus(6'd17, 32'hDEAD_BEEF, 7'h11, 3'd1, 8'd3);
        n = 0;
        while (rise_cnt != 28 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("reach_send_bit20", 64'(rise_cnt), 64'd28);
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        checkOutput("midrst_timeout", 64'(timeout), 64'd0);
        checkOutput("midrst_resp", 64'(resp), 64'hFF_FFFF_FFFF);
        checkOutput("midrst_sclk", 64'(sd_cclk), 64'd0);
        checkOutput("midrst_mosi", 64'(sd_cmd), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        setStream(3, 40'h00_1234_5678);
        applyStimulus(6'd13, 32'h0000_0000, 7'h7F, 3'd3, 8'd2);
        finishTransaction(1'b0);

        $display("[TB] div 1 with a start while busy");
        setStream(7, 40'h01_8081_FFFF);
        applyStimulus(6'd41, 32'h8000_0000, 7'h3B, 3'd3, 8'd1);
        finishTransaction(1'b1);

        $display("[TB] div 0 and oversize resp_bytes");
        setStream(0, 40'h3C_A5A5_0F0F);
        applyStimulus(6'd58, 32'h0F0F_F0F0, 7'h55, 3'd7, 8'd0);
        finishTransaction(1'b0);

`ifdef SD_SPI_CMD_CRC7_EN
        $display("[TB] internal CRC7 with cmd_crc zero");
        setStream(16, 40'h01_FFFF_FFFF);
        applyStimulus(6'd0, 32'h0, 7'h00, 3'd1, 8'd2);
        finishTransaction(1'b0);
        checkOutput("crc7_last_byte", 64'(mosi_cap[7:0]), 64'h95);
`endif

        $display("[TB] randomized commands");
        for (int t = 0; t < 8; t++) begin
            r = {$urandom(), $urandom()};
            setStream($urandom_range(0, 60), {1'b0, r[38:0]});
            applyStimulus(6'($urandom_range(0, 63)), $urandom(), 7'($urandom_range(0, 127)),
                          3'($urandom_range(0, 7)), 8'($urandom_range(1, 4)));
            finishTransaction(1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
